// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and helpers for the register load arbiter
package reg_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    CLEAR = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic STROBE_ACTIVE = 1'b0;

  function automatic int idx_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first set request at or after ptr
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down so the nearest hit to ptr is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      int cand;
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// rtl/reg_load_arbiter.sv - round-robin sharing of one load-strobed register between requesters
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          clr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          clr_ack_o,
  output logic                          busy_o,
  output logic                          ld_no,
  output logic                          rst_no,
  output logic [DATA_WIDTH-1:0]         reg_data_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    ptr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_i),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_data      = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        pick_onehot[k] = 1'b1;
      end
    end
  end

  assign ptr_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      gnt_o      <= '0;
      ack_o      <= '0;
      clr_ack_o  <= 1'b0;
      busy_o     <= 1'b0;
      ld_no      <= ~STROBE_ACTIVE;
      rst_no     <= ~STROBE_ACTIVE;
      reg_data_o <= '0;
    end else begin
      ack_o     <= '0;
      clr_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          // The clr_ack cycle is the clear handshake: clr_i is still seen high
          // there, so it must not start a second clear.
          if (clr_i && !clr_ack_o) begin
            rst_no <= STROBE_ACTIVE;
            busy_o <= 1'b1;
            state  <= CLEAR;
          end else if (pick_valid) begin
            win        <= pick_idx;
            gnt_o      <= pick_onehot;
            reg_data_o <= pick_data;
            busy_o     <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          ld_no <= STROBE_ACTIVE;
          state <= LOAD;
        end
        LOAD: begin
          ld_no <= ~STROBE_ACTIVE;
          ack_o <= gnt_o;
          state <= ACK;
        end
        ACK: begin
          gnt_o  <= '0;
          ptr    <= ptr_next;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        CLEAR: begin
          rst_no    <= ~STROBE_ACTIVE;
          clr_ack_o <= 1'b1;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt_o  <= '0;
          ld_no  <= ~STROBE_ACTIVE;
          rst_no <= ~STROBE_ACTIVE;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb/tb_reg_load_arbiter.sv - directed table-driven bench for reg_load_arbiter
module tb_reg_load_arbiter;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [3:0]  req;
  logic [15:0] d [4];
  logic [63:0] data;
  logic        clr;
  logic [3:0]  gnt_o, ack_o;
  logic        clr_ack_o, busy_o, ld_no, rst_no;
  logic [15:0] reg_data_o;
  logic [15:0] mreg;

  int n_chk  = 0;
  int n_fail = 0;

  assign data = {d[3], d[2], d[1], d[0]};

  reg_load_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .req_i      (req),
    .data_i     (data),
    .clr_i      (clr),
    .gnt_o      (gnt_o),
    .ack_o      (ack_o),
    .clr_ack_o  (clr_ack_o),
    .busy_o     (busy_o),
    .ld_no      (ld_no),
    .rst_no     (rst_no),
    .reg_data_o (reg_data_o)
  );

  always #5 clk = ~clk;

  // Shared register as seen downstream: captures on negedge.
  always @(negedge clk) begin
    if (!rst_no) mreg <= 16'h0000;
    else if (!ld_no) mreg <= reg_data_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_ni === 1'b1) chk("strobe_overlap", {30'd0, ld_no, rst_no}, (ld_no || rst_no) ? {30'd0, ld_no, rst_no} : 32'd1);
  end

  // One cycle forward; lands 1 time unit after the negedge.
  task automatic step();
    @(posedge clk);
    #6;
  endtask

  typedef struct {
    logic [3:0]  raise;
    logic        clr;
    logic        chg_d1;
    logic        clr_mid;
    logic [3:0]  gnt;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic [3:0] raise, input logic c, input logic chg,
                              input logic cm, input logic [3:0] g, input logic [15:0] dv);
    vec_t v;
    v.raise = raise; v.clr = c; v.chg_d1 = chg; v.clr_mid = cm; v.gnt = g; v.dat = dv;
    return v;
  endfunction

  task automatic run_entry(input int i, input vec_t e);
    req = req | e.raise;
    if (e.clr) clr = 1'b1;
    if (e.clr) begin
      step();
      chk($sformatf("e%0d clear rst_no", i), rst_no, 0);
      chk($sformatf("e%0d clear ld_no", i), ld_no, 1);
      chk($sformatf("e%0d clear busy", i), busy_o, 1);
      chk($sformatf("e%0d clear gnt", i), gnt_o, 0);
      step();
      chk($sformatf("e%0d clr_ack", i), clr_ack_o, 1);
      chk($sformatf("e%0d clear rst_no release", i), rst_no, 1);
      chk($sformatf("e%0d clear busy drop", i), busy_o, 0);
      chk($sformatf("e%0d cleared reg", i), mreg, 0);
      clr = 1'b0;
    end else begin
      step();
      chk($sformatf("e%0d grant gnt", i), gnt_o, e.gnt);
      chk($sformatf("e%0d grant ld_no", i), ld_no, 1);
      chk($sformatf("e%0d grant busy", i), busy_o, 1);
      chk($sformatf("e%0d grant ack", i), ack_o, 0);
      chk($sformatf("e%0d grant data", i), reg_data_o, e.dat);
      if (e.chg_d1) d[1] = 16'h5678;
      if (e.clr_mid) begin
        clr = 1'b1;
        req = req | 4'b1000;
      end
      step();
      chk($sformatf("e%0d load gnt", i), gnt_o, e.gnt);
      chk($sformatf("e%0d load ld_no", i), ld_no, 0);
      chk($sformatf("e%0d load ack", i), ack_o, 0);
      step();
      chk($sformatf("e%0d ack ack", i), ack_o, e.gnt);
      chk($sformatf("e%0d ack gnt", i), gnt_o, e.gnt);
      chk($sformatf("e%0d ack ld_no", i), ld_no, 1);
      chk($sformatf("e%0d ack reg", i), mreg, e.dat);
      req = req & ~e.gnt;
      step();
      chk($sformatf("e%0d idle gnt", i), gnt_o, 0);
      chk($sformatf("e%0d idle ack", i), ack_o, 0);
      chk($sformatf("e%0d idle busy", i), busy_o, 0);
      chk($sformatf("e%0d idle clr_ack", i), clr_ack_o, 0);
    end
  endtask

  initial begin
    tbl[0]  = mk(4'b1000, 0, 0, 0, 4'b1000, 16'h3333);
    tbl[1]  = mk(4'b1111, 0, 0, 0, 4'b0001, 16'h1111);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 4'b0010, 16'h1234);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 4'b0100, 16'hBEEF);
    tbl[4]  = mk(4'b0000, 0, 0, 0, 4'b1000, 16'h3333);
    tbl[5]  = mk(4'b1001, 0, 0, 0, 4'b0001, 16'h1111);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 4'b1000, 16'h3333);
    tbl[7]  = mk(4'b0100, 0, 0, 0, 4'b0100, 16'hBEEF);
    tbl[8]  = mk(4'b1001, 0, 0, 0, 4'b1000, 16'h3333);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 4'b0001, 16'h1111);
    tbl[10] = mk(4'b0010, 1, 0, 0, 4'b0000, 16'h0000);
    tbl[11] = mk(4'b0000, 0, 0, 0, 4'b0010, 16'h1234);
    tbl[12] = mk(4'b0010, 0, 1, 0, 4'b0010, 16'h1234);
    tbl[13] = mk(4'b0010, 0, 0, 0, 4'b0010, 16'h5678);
    tbl[14] = mk(4'b0001, 0, 0, 1, 4'b0001, 16'h1111);
    tbl[15] = mk(4'b0000, 1, 0, 0, 4'b0000, 16'h0000);
    tbl[16] = mk(4'b0000, 0, 0, 0, 4'b1000, 16'h3333);

    d[0] = 16'h1111; d[1] = 16'h1234; d[2] = 16'hBEEF; d[3] = 16'h3333;
    req = 4'b0000; clr = 1'b0; reset_ni = 1'b0;
    step();
    step();
    chk("reset gnt", gnt_o, 0);
    chk("reset ld_no", ld_no, 1);
    chk("reset rst_no", rst_no, 1);
    chk("reset busy", busy_o, 0);
    chk("reset reg_data", reg_data_o, 0);
    reset_ni = 1'b1;

    // Abort a transaction mid-LOAD with an asynchronous reset.
    req = 4'b0010;
    step();
    chk("abort grant", gnt_o, 4'b0010);
    step();
    chk("abort in load", ld_no, 0);
    #1 reset_ni = 1'b0;
    #1;
    chk("abort ld_no", ld_no, 1);
    chk("abort gnt", gnt_o, 0);
    chk("abort ack", ack_o, 0);
    chk("abort busy", busy_o, 0);
    chk("abort reg_data", reg_data_o, 0);
    req = 4'b0000;
    step();
    chk("abort no ack", ack_o, 0);
    reset_ni = 1'b1;
    step();
    chk("post reset ack", ack_o, 0);
    chk("post reset gnt", gnt_o, 0);

    for (int i = 0; i < 17; i++) run_entry(i, tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
